// File: rtl/debug_command_controller_if.sv
// debug_command_controller_if: UART byte stream, CPU debug control and instruction-memory programming bundle
interface debug_command_controller_if #(
    parameter int PROG_ADDR_W = 14
);
    logic                   rx_valid;
    logic [7:0]             rx_data;
    logic                   tx_ready;
    logic                   tx_valid;
    logic [7:0]             tx_data;
    logic [31:0]            cpu_pc;
    logic                   cpu_pc_valid;
    logic                   cpu_retire;
    logic                   cpu_pause;
    logic                   cpu_step;
    logic                   cpu_restart;
    logic                   prog_en;
    logic                   prog_we;
    logic [PROG_ADDR_W-1:0] prog_addr;
    logic [31:0]            prog_data;

    modport master (
        input  rx_valid, rx_data, tx_ready, cpu_pc, cpu_pc_valid, cpu_retire,
        output tx_valid, tx_data, cpu_pause, cpu_step, cpu_restart,
               prog_en, prog_we, prog_addr, prog_data
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, cpu_pc, cpu_pc_valid, cpu_retire,
        input  tx_valid, tx_data, cpu_pause, cpu_step, cpu_restart,
               prog_en, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/debug_command_controller.sv
// debug_command_controller: parses UART debug commands, drives CPU pause/step/breakpoint and imem programming, sends replies.
// Optional macro DEBUG_STATUS_EN appends status {5'b0, bp_en, last_pause_by_breakpoint, cpu_pause} to every report frame.
module debug_command_controller #(
    parameter int PROG_ADDR_W = 14,
    parameter int ARG_TIMEOUT = 2000000
) (
    input logic clk,
    input logic rst_n,
    debug_command_controller_if.master bus
);
    localparam logic [7:0] OP_SIGNAL  = 8'h01;
    localparam logic [7:0] OP_OK      = 8'h02;
    localparam logic [7:0] OP_PING    = 8'h03;
    localparam logic [7:0] OP_PAUSE   = 8'h04;
    localparam logic [7:0] OP_RESUME  = 8'h05;
    localparam logic [7:0] OP_NEXT    = 8'h06;
    localparam logic [7:0] OP_PROGRAM = 8'h07;
    localparam int TW = $clog2(ARG_TIMEOUT + 1);
`ifdef DEBUG_STATUS_EN
    localparam logic [2:0] TX_LAST = 3'd5;
`else
    localparam logic [2:0] TX_LAST = 3'd4;
`endif

    typedef enum logic [2:0] {
        IDLE, SEND_OK, REPORT, BP_ARG, STEP_WAIT, CNT_ARG, PROG_DATA, PROG_DONE
    } state_t;

    state_t state, state_next;

    logic                   tx_valid;
    logic [7:0]             tx_data;
    logic                   cpu_pause;
    logic                   cpu_step;
    logic                   cpu_restart;
    logic                   prog_en;
    logic                   prog_we;
    logic [PROG_ADDR_W-1:0] prog_addr;
    logic [31:0]            prog_data;

    logic [31:0]   bp_addr, bp_pc, pc_lat, wcnt, widx, word;
    logic [23:0]   sh;
    logic          bp_en, bp_pend;
    logic [1:0]    bcnt;
    logic [2:0]    tx_idx, tx_sel;
    logic [TW-1:0] tmo;
    logic [7:0]    tx_byte;
    logic          cmd_v, c_ping, c_pause, c_resume, c_next, c_prog, go_bp;
    logic          arg_st, arg_word, timeout, bp_hit, tx_last;
`ifdef DEBUG_STATUS_EN
    logic          last_bp;
`endif

    assign bus.tx_valid    = tx_valid;
    assign bus.tx_data     = tx_data;
    assign bus.cpu_pause   = cpu_pause;
    assign bus.cpu_step    = cpu_step;
    assign bus.cpu_restart = cpu_restart;
    assign bus.prog_en     = prog_en;
    assign bus.prog_we     = prog_we;
    assign bus.prog_addr   = prog_addr;
    assign bus.prog_data   = prog_data;

    // Command decode, argument assembly, breakpoint match and reply byte selection
    always_comb begin
        cmd_v    = state == IDLE && bus.rx_valid;
        c_ping   = cmd_v && bus.rx_data == OP_PING;
        c_pause  = cmd_v && bus.rx_data == OP_PAUSE;
        c_resume = cmd_v && bus.rx_data == OP_RESUME;
        c_next   = cmd_v && bus.rx_data == OP_NEXT && cpu_pause;
        c_prog   = cmd_v && bus.rx_data == OP_PROGRAM;
        go_bp    = state == IDLE && bp_pend && !(c_ping || c_pause || c_resume || c_next || c_prog);
        arg_st   = state inside {BP_ARG, CNT_ARG, PROG_DATA};
        word     = {bus.rx_data, sh};
        arg_word = arg_st && bus.rx_valid && bcnt == 2'd3;
        timeout  = arg_st && !bus.rx_valid && tmo == TW'(ARG_TIMEOUT - 1);
        bp_hit   = bp_en && !cpu_pause && bus.cpu_pc_valid && bus.cpu_pc == bp_addr;
        tx_last  = state == SEND_OK || tx_idx == TX_LAST;
        tx_sel   = tx_valid ? tx_idx + 3'd1 : tx_idx;
        tx_byte  = state == SEND_OK ? OP_OK :
                   tx_sel == 3'd0   ? OP_SIGNAL :
                   tx_sel == 3'd1   ? pc_lat[7:0] :
                   tx_sel == 3'd2   ? pc_lat[15:8] :
                   tx_sel == 3'd3   ? pc_lat[23:16] :
`ifdef DEBUG_STATUS_EN
                   tx_sel == 3'd4   ? pc_lat[31:24] : {5'b0, bp_en, last_bp, cpu_pause};
`else
                   pc_lat[31:24];
`endif
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = c_ping ? SEND_OK :
                                    (c_pause || go_bp) ? REPORT :
                                    c_resume ? BP_ARG :
                                    c_next ? STEP_WAIT :
                                    c_prog ? CNT_ARG : IDLE;
            BP_ARG:    state_next = (timeout || arg_word) ? IDLE : BP_ARG;
            CNT_ARG:   state_next = timeout ? IDLE : !arg_word ? CNT_ARG :
                                    word == 32'd0 ? PROG_DONE : PROG_DATA;
            PROG_DATA: state_next = timeout ? IDLE :
                                    (arg_word && widx + 32'd1 == wcnt) ? PROG_DONE : PROG_DATA;
            PROG_DONE: state_next = SEND_OK;
            STEP_WAIT: state_next = bus.cpu_retire ? REPORT : STEP_WAIT;
            default:   state_next = (tx_valid && bus.tx_ready && tx_last) ? IDLE : state;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end

    // Little-endian argument shifter and inter-byte idle timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            bcnt <= 2'd0;
            tmo  <= '0;
        end else begin
            tmo <= (arg_st && !bus.rx_valid) ? tmo + TW'(1) : '0;
            if (state == IDLE) bcnt <= 2'd0;
            if (arg_st && bus.rx_valid) begin
                sh   <= word[31:8];
                bcnt <= bcnt + 2'd1;
            end
        end
    end

    // CPU pause/step, breakpoint capture and the PC reported in the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_pause <= 1'b0;
            cpu_step  <= 1'b0;
            bp_addr   <= '0;
            bp_en     <= 1'b0;
            bp_pend   <= 1'b0;
            bp_pc     <= '0;
            pc_lat    <= '0;
`ifdef DEBUG_STATUS_EN
            last_bp   <= 1'b0;
`endif
        end else begin
            cpu_step <= c_next;
            bp_pend  <= (state == IDLE && state_next == REPORT) ? 1'b0 : bp_pend || bp_hit;
            if (bp_hit) begin
                cpu_pause <= 1'b1;
                bp_pc     <= bus.cpu_pc;
`ifdef DEBUG_STATUS_EN
                last_bp   <= 1'b1;
`endif
            end
            if (c_pause || c_prog) begin
                cpu_pause <= 1'b1;
`ifdef DEBUG_STATUS_EN
                if (!cpu_pause) last_bp <= 1'b0;
`endif
            end
            if (c_pause) pc_lat <= bus.cpu_pc;
            if (go_bp) pc_lat <= bp_pc;
            if (state == STEP_WAIT && bus.cpu_retire) pc_lat <= bus.cpu_pc;
            if (state == BP_ARG && arg_word) begin
                bp_addr   <= word;
                bp_en     <= word != 32'd0;
                cpu_pause <= 1'b0;
            end
        end
    end

    // Instruction-memory programming: word count, per-word write strobe, restart on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_en     <= 1'b0;
            prog_we     <= 1'b0;
            prog_addr   <= '0;
            prog_data   <= '0;
            cpu_restart <= 1'b0;
            wcnt        <= '0;
            widx        <= '0;
        end else begin
            prog_we     <= 1'b0;
            cpu_restart <= state == PROG_DONE;
            if (c_prog) prog_en <= 1'b1;
            if (state == PROG_DONE || (timeout && state != BP_ARG)) prog_en <= 1'b0;
            if (state == CNT_ARG && arg_word) begin
                wcnt <= word;
                widx <= '0;
            end
            if (state == PROG_DATA && arg_word) begin
                widx <= widx + 32'd1;
                if ((widx >> PROG_ADDR_W) == 32'd0) begin
                    prog_we   <= 1'b1;
                    prog_addr <= widx[PROG_ADDR_W-1:0];
                    prog_data <= word;
                end
            end
        end
    end

    // Reply transmitter: holds each byte until accepted, next byte follows on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            tx_idx   <= 3'd0;
        end else if (state == SEND_OK || state == REPORT) begin
            if (!tx_valid) begin
                tx_valid <= 1'b1;
                tx_data  <= tx_byte;
            end else if (bus.tx_ready) begin
                tx_valid <= !tx_last;
                tx_idx   <= tx_last ? 3'd0 : tx_idx + 3'd1;
                if (!tx_last) tx_data <= tx_byte;
            end
        end
    end
endmodule

// File: doc/debug_command_controller.md
Name: debug_command_controller

Overview:
- Sequences the CPU debug path.
- Parses bytes from the UART receiver into debug commands: PING, PAUSE, RESUME with breakpoint, NEXT and PROGRAM.
- Drives CPU pause, single-step, breakpoint and instruction-memory reprogramming.
- Sequences replies (OP_OK, OP_SIGNAL plus PC) to the UART transmitter.
- Sits between uart rx/tx and the CPU core inside top.

Parameters:
- PROG_ADDR_W, 14: instruction-memory word-address width.
- ARG_TIMEOUT, 2000000: idle cycles allowed between argument bytes before a command is aborted.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: asynchronous active-low reset.
- rx_valid  in  1: one-cycle pulse, rx_data holds a received byte.
- rx_data  in  8: received byte.
- tx_ready  in  1: transmitter can accept a byte.
- tx_valid  out  1: tx_data is valid.
- tx_data  out  8: byte to transmit.
- cpu_pc  in  32: PC of the instruction about to execute.
- cpu_pc_valid  in  1: cpu_pc updated this cycle (new instruction fetched).
- cpu_retire  in  1: one-cycle pulse, one instruction completed.
- cpu_pause  out  1: holds the CPU pipeline.
- cpu_step  out  1: one-cycle pulse, releases exactly one instruction while paused.
- cpu_restart  out  1: one-cycle pulse, PC to 0 after programming.
- prog_en  out  1: programming mode active.
- prog_we  out  1: one-cycle instruction-memory write strobe.
- prog_addr  out  PROG_ADDR_W: word address.
- prog_data  out  32: word to write.

Behaviour:
- Reset values: cpu_pause=0 (CPU runs), tx_valid=0, tx_data=8'h00, cpu_step=0, cpu_restart=0, prog_en=0, prog_we=0, prog_addr=0, prog_data=0. bp_addr=0, bp_en=0. State IDLE.
- Reset mid-command or mid-transmission: everything returns to reset values immediately; partial bytes are discarded.
- Opcodes: PING=03, PAUSE=04, RESUME=05, NEXT=06, PROGRAM=07. Replies: SIGNAL=01, OK=02.
- Bytes other than 03-07 in IDLE are ignored.
- Report frame: SIGNAL byte followed by cpu_pc as 4 bytes, LSB first.
- States and transitions:
  - IDLE, PING: goes to SEND_OK.
  - IDLE, PAUSE: cpu_pause=1 on the next edge, then REPORT. PAUSE while already paused also goes to REPORT.
  - IDLE, RESUME: goes to BP_ARG, which collects 4 bytes, LSB first, into bp_addr.
    - After the 4th byte: bp_en = (bp_addr != 0), cpu_pause=0, back to IDLE with no reply.
    - RESUME while running only updates the breakpoint.
  - IDLE, NEXT while paused: cpu_step high for 1 cycle, then STEP_WAIT.
    - STEP_WAIT waits for cpu_retire, then REPORT.
    - NEXT while running is ignored.
  - IDLE, PROGRAM: prog_en=1 and cpu_pause=1 immediately.
    - CNT_ARG collects a 4-byte word count N, LSB first.
    - PROG_DATA collects N words of 4 bytes, LSB first.
    - prog_we pulses 1 cycle per completed word, with prog_addr = word index.
    - Words with index >= 2^PROG_ADDR_W are consumed but not written (no wrap).
    - N=0 skips PROG_DATA.
    - On completion: prog_en=0, cpu_restart pulses 1 cycle, CPU stays paused, then SEND_OK.
  - SEND_OK: sends OK byte, then IDLE.
  - REPORT: sends the report frame, then IDLE.
- Breakpoint: in IDLE with cpu_pause=0 and bp_en, a cycle with cpu_pc_valid && cpu_pc==bp_addr sets cpu_pause=1 on the next edge. The controller latches the PC and enters REPORT. The matched instruction is not executed.
  - A breakpoint hit in any other state is deferred until IDLE, using the latched PC.
- Tx handshake:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - tx_data is stable while tx_valid && !tx_ready.
  - At most one byte is presented per cycle; the next byte may follow on the cycle after acceptance.
- rx bytes arriving in SEND_OK, REPORT or STEP_WAIT are dropped.
- Timeout: in BP_ARG, CNT_ARG or PROG_DATA, ARG_TIMEOUT cycles without rx_valid abort to IDLE.
  - Aborted RESUME: bp unchanged, pause unchanged.
  - Aborted PROGRAM: prog_en=0, no cpu_restart, CPU stays paused, no reply.
- Simultaneous rx_valid with a breakpoint match: the match is captured first; the byte is processed normally if in IDLE.

Optional Feature:
- Macro DEBUG_STATUS_EN.
- Defined: the report frame has a 5th byte, status = {5'b0, bp_en, last_pause_by_breakpoint, cpu_pause}.
- Undefined: 4-byte PC payload only; no status logic.

Test Plan:
- Reset, rx 03 -> tx 02 exactly once; cpu_pause stays 0.
- rx 04 with cpu_pc=0x00000010 -> cpu_pause=1; tx 01,10,00,00,00.
- Paused, rx 06, retire with pc=0x14 -> cpu_step high exactly 1 cycle; tx 01,14,00,00,00. Repeat rx 06 while running -> no step, no tx.
- rx 05,04,00,00,00, then fetch sequence pc=0,4 -> cpu_pause=1 the edge after pc=4 is valid; tx 01,04,00,00,00.
- rx 05,00,00,00,00 -> bp_en=0; CPU runs past every PC with no tx.
- rx 07,02,00,00,00,78,56,34,12,EF,BE,AD,DE -> prog_we at addr 0 with data 0x12345678, at addr 1 with data 0xDEADBEEF; cpu_restart pulse; tx 02.
- rx 07,02 then silence for ARG_TIMEOUT cycles -> prog_en=0, no tx; a following 03 is answered with 02.
- tx_ready held low 100 cycles mid-frame -> tx_data stable, no byte lost.
